mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage directly downstream of the EX/MEM pipeline register; consumes its alu_out, rs2_out and control fields.
//  Issues one data-memory transaction per load/store and freezes the pipeline until the memory responds.
//  Holds the returned word until MEM/WB advances, so an instruction is never re-issued during an unrelated stall.
//  Formats load data (sign/zero extend) and store data (shift, byte enables) for RV32I.
// PARAMETERS
//  ADDR_W   32  data address width
//  DATA_W   32  data bus width; only 32 supported, mbe width = DATA_W/8
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  valid_i      in   1       EX/MEM holds a live (non-bubble) instruction
//  load_i       in   1       instruction is a load
//  store_i      in   1       instruction is a store
//  funct3_i     in   3       load/store width: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr_i       in   ADDR_W  effective address (EX/MEM alu_out)
//  wdata_i      in   DATA_W  store data (EX/MEM rs2_out)
//  advance_i    in   1       MEM/WB enable this cycle (global pipeline advance)
//  dmem_read    out  1       read request to data cache
//  dmem_write   out  1       write request to data cache
//  dmem_addr    out  ADDR_W  word-aligned address {addr_i[31:2],2'b00}
//  dmem_wdata   out  DATA_W  store data shifted to byte lane
//  dmem_mbe     out  4       byte enables
//  dmem_rdata   in   DATA_W  read data, valid with dmem_resp
//  dmem_resp    in   1       one-cycle transaction completion
//  stall_o      out  1       freeze IF..EX/MEM (drives EX/MEM en low)
//  load_data_o  out  DATA_W  formatted load result to MEM/WB
//  misalign_o   out  1       current op is misaligned; no request issued
// BEHAVIOUR
//  mem_op = valid_i & (load_i | store_i) & ~misalign_o. Misaligned: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0.
//  FSM states IDLE, BUSY, HOLD; reset -> IDLE.
//   IDLE: mem_op -> request asserted this cycle; dmem_resp -> (advance_i ? IDLE : HOLD); else -> BUSY.
//   BUSY: request held stable; dmem_resp -> (advance_i ? IDLE : HOLD); else stay.
//   HOLD: no request; advance_i -> IDLE.
//  Requests (dmem_read = load_i, dmem_write = store_i) are combinational and asserted only in IDLE with mem_op, or in BUSY.
//  Address, wdata and mbe stay constant from first assert to dmem_resp (guaranteed by stall_o freezing EX/MEM).
//  stall_o = mem_op & (state != HOLD) & ~dmem_resp. Zero-wait response (resp in the issue cycle) gives no stall.
//  On dmem_resp of a load: register rdata, addr[1:0] and funct3 together; load_data_o derives from the registered copy.
//  Load: b/bu pick byte addr[1:0], h/hu pick half addr[1]; b/h sign-extend, bu/hu zero-extend, w pass.
//  Store: sb mbe=4'b0001<<addr[1:0], wdata=byte<<8*addr[1:0]; sh mbe=4'b0011<<addr[1:0], half<<8*addr[1:0]; sw mbe=4'hF.
//  Unused funct3: no request, treated as word-sized alignment check, load_data_o=0.
//  valid_i=0 or misalign: no request, stall_o=0, FSM untouched in IDLE.
//  Reset (any state, incl. mid-transaction): state IDLE, load register 0, all outputs 0; any late dmem_resp ignored in IDLE
//   unless a new request is asserted.
//  Store + advance low at resp: HOLD; store is not repeated.
// STRUCTURE
//  rv32i_types package: load_funct3_t, store_funct3_t enums; mem_state_t {IDLE,BUSY,HOLD}.
//  Sub-module mem_align: combinational store shift/mbe and load extract/extend; mem_stage keeps FSM + capture regs.
// TESTING
//  lw addr 0x100, resp after 3 cycles rdata 0xDEADBEEF, advance=1 -> stall 3 cycles, load_data_o 0xDEADBEEF.
//  lb addr 0x103 rdata 0x80112233 -> 0xFFFFFF80; lbu -> 0x00000080; lhu addr 0x102 -> 0x00008011.
//  sb addr 0x201 wdata 0x000000AB -> dmem_mbe 0010, dmem_wdata 0x0000AB00, dmem_addr 0x200.
//  lw resp with advance_i=0 for 2 cycles -> HOLD, dmem_read low, stall_o low, data held; advance -> IDLE.
//  lw addr 0x102 -> misalign_o=1, no dmem_read, stall_o=0.
//  rst_n low during BUSY -> IDLE, outputs 0; stray dmem_resp next cycle with valid_i=0 -> no state change.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I load/store encodings and MEM-stage state type.
package rv32i_types;

    typedef enum logic [2:0] {
        LF_B  = 3'b000,
        LF_H  = 3'b001,
        LF_W  = 3'b010,
        LF_BU = 3'b100,
        LF_HU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SF_B = 3'b000,
        SF_H = 3'b001,
        SF_W = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return f3 inside {LF_B, LF_H, LF_W, LF_BU, LF_HU};
        return f3 inside {SF_B, SF_H, SF_W};
    endfunction

    // Illegal encodings fall back to the word alignment rule.
    function automatic logic misaligned(input logic legal, input logic [1:0] size,
                                        input logic [1:0] off);
        if (!legal || size == 2'b10)
            return off != 2'b00;
        if (size == 2'b01)
            return off[0];
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane formatting for RV32I: store shift/byte enables and load extract/extend.
module mem_align
    import rv32i_types::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          st_funct3,
    input  logic [1:0]          st_off,
    input  logic [DATA_W-1:0]   st_data,
    output logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_mbe,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_off,
    input  logic [DATA_W-1:0]   ld_rdata,
    output logic [DATA_W-1:0]   ld_data
);

    localparam int MBE_W = DATA_W / 8;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_wdata = '0;
        st_mbe   = '0;
        case (st_funct3)
            SF_B: begin
                st_mbe   = MBE_W'(1) << st_off;
                st_wdata = DATA_W'(st_data[7:0]) << {st_off, 3'b000};
            end
            SF_H: begin
                st_mbe   = MBE_W'(3) << st_off;
                st_wdata = DATA_W'(st_data[15:0]) << {st_off, 3'b000};
            end
            SF_W: begin
                st_mbe   = '1;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

    assign byte_sel = 8'(ld_rdata >> {ld_off, 3'b000});
    assign half_sel = ld_off[1] ? ld_rdata[DATA_W-1:16] : ld_rdata[15:0];

    always_comb begin
        ld_data = '0;
        case (ld_funct3)
            LF_B:    ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LF_BU:   ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LF_H:    ld_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LF_HU:   ld_data = {{(DATA_W-16){1'b0}}, half_sel};
            LF_W:    ld_data = ld_rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one data-memory transaction per load/store, stalls until the
// response, and holds the returned word until MEM/WB advances.
//
//   state | meaning
//   IDLE  | no transaction outstanding; a new op issues its request this cycle
//   BUSY  | request issued, waiting for dmem_resp; request held stable
//   HOLD  | response captured, waiting for advance_i; no request
module mem_stage
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic                load_i,
    input  logic                store_i,
    input  logic [2:0]          funct3_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                advance_i,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W/8-1:0] dmem_mbe,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_resp,
    output logic                stall_o,
    output logic [DATA_W-1:0]   load_data_o,
    output logic                misalign_o
);

    mem_state_t          state;
    logic                legal;
    logic                mem_op;
    logic                req_active;
    logic                store_req;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          off_q;
    logic [2:0]          f3_q;
    logic [DATA_W-1:0]   st_wdata;
    logic [DATA_W/8-1:0] st_mbe;

    assign legal      = f3_legal(load_i, funct3_i);
    assign misalign_o = valid_i & (load_i | store_i)
                        & misaligned(legal, funct3_i[1:0], addr_i[1:0]);
    assign mem_op     = valid_i & (load_i | store_i) & legal & ~misalign_o;

    assign req_active = ((state == IDLE) & mem_op) | (state == BUSY);
    assign store_req  = req_active & store_i;

    assign dmem_read  = req_active & load_i;
    assign dmem_write = store_req;
    assign dmem_addr  = req_active ? {addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata = store_req ? st_wdata : '0;
    assign dmem_mbe   = store_req ? st_mbe : '0;

    // A response in the issue cycle releases the pipeline without a bubble.
    assign stall_o = mem_op & (state != HOLD) & ~dmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
        end else begin
            if (req_active && dmem_resp && load_i) begin
                rdata_q <= dmem_rdata;
                off_q   <= addr_i[1:0];
                f3_q    <= funct3_i;
            end
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (dmem_resp)
                            state <= advance_i ? IDLE : HOLD;
                        else
                            state <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_resp)
                        state <= advance_i ? IDLE : HOLD;
                end
                HOLD: begin
                    if (advance_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .st_funct3(funct3_i),
        .st_off   (addr_i[1:0]),
        .st_data  (wdata_i),
        .st_wdata (st_wdata),
        .st_mbe   (st_mbe),
        .ld_funct3(f3_q),
        .ld_off   (off_q),
        .ld_rdata (rdata_q),
        .ld_data  (load_data_o)
    );

endmodule
